alu_rr_scheduler: RTL
=====================

# alu_rr_scheduler

Round-robin scheduler that shares a single combinational 8-bit ALU (`command_t` in, 8-bit result out) among `NUM_REQ` requesters. It accepts one packed command per transaction over a valid/ready handshake and drives it onto the shared ALU. It registers the result and returns it to the requester with the requester's index and an error flag for unsupported opcodes. It sits between the client blocks and the `aluInstr`/`command_t` datapath, and is the only driver of the ALU's command input.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester command valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit set in any cycle.
- `req_cmd` in `NUM_REQ*19`: packed `command_t` per requester. Requester i occupies bits [19*i+18 : 19*i]. Within each slice: oper [18:16], inA [15:8], inB [7:0].
- `alu_cmd` out 19: `command_t` to the shared ALU.
- `alu_result` in 8: ALU result, combinational from `alu_cmd`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_data` out 8: result.
- `rsp_id` out `ID_W`: index of the requester the response belongs to.
- `rsp_err` out 1: the command's oper was not a legal `aluInstr` code.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - Search `req_valid` starting at `rr_ptr`, ascending with wrap modulo `NUM_REQ`. The first set bit is the grant g.
  - `req_ready[g]` = 1 combinationally in this cycle; all other ready bits = 0. The handshake completes in the same cycle.
  - On the clock edge: latch `req_cmd` slice g into `cmd_q`, latch g into `id_q`, set `rr_ptr` <= (g+1) mod `NUM_REQ`, and go to EXEC.
  - If no `req_valid` bit is set, `req_ready` = 0 and the FSM stays in IDLE.
- **EXEC** (exactly one cycle)
  - `alu_cmd` = `cmd_q`.
  - If oper is one of 100 (ADD), 010 (SUB), 001 (AND), 110 (OR) or 011 (XOR): `rsp_data` <= `alu_result` and `rsp_err` <= 0.
  - Otherwise: `rsp_data` <= 0 and `rsp_err` <= 1, and `alu_result` is ignored.
  - `rsp_id` <= `id_q`. Go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_data`, `rsp_id` and `rsp_err` are held stable until `rsp_ready` = 1.
  - When `rsp_ready` = 1, go to IDLE on the next clock edge.
  - `req_ready` = 0 throughout RESP.
- `alu_cmd` always equals `cmd_q`. It changes only on a grant.
- Arithmetic is 8-bit modulo; ADD carry and SUB borrow are discarded.
- Only one transaction is in flight at a time. No command is accepted while in EXEC or RESP.
- A requester that drops `req_valid` before it is granted loses nothing. The scheduler keeps no per-requester state except `rr_ptr`.
- Reset values: state IDLE, `rr_ptr` 0, `cmd_q` 0 (so `alu_cmd` = 0), `id_q` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `rsp_err` 0, `req_ready` all 0.
- Reset asserted mid-transaction: the in-flight command is dropped and no response is issued. All registers take their reset values on the first edge with `rst_n` = 0. `req_ready` is forced to 0 while `rst_n` = 0.

## Timing
- Cycle 0: IDLE, handshake on `req_valid[g]` and `req_ready[g]`.
- Cycle 1: EXEC, `alu_cmd` holds the command.
- Cycle 2: RESP, `rsp_valid` = 1. Latency from acceptance to `rsp_valid` is 2 cycles.
- With `rsp_ready` tied high, a new grant occurs in cycle 3. Peak throughput is one command per 3 cycles.
- Each cycle `rsp_ready` stays low while `rsp_valid` = 1 adds one cycle.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr` and state. It has no combinational path from `rsp_ready`.
- `rsp_*` outputs are registered. `alu_cmd` is registered.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, …, `NUM_REQ`-1, 0, … Each requester waits at most `NUM_REQ`-1 other transactions.

## Test plan
- Single request, requester 2: ADD inA=0xF0, inB=0x20. Required: `req_ready[2]` high in cycle 0; `alu_cmd` = {100, F0, 20} in cycle 1; `rsp_valid` in cycle 2 with `rsp_data`=0x10, `rsp_id`=2, `rsp_err`=0.
- All four requesters valid from reset, `rsp_ready`=1, ops SUB 05-07 / AND F0&3C / OR 0F|30 / XOR FF^0F. Required: grants in order 0, 1, 2, 3, then 0 again; responses 0xFE, 0x30, 0x3F, 0xF0; consecutive grants 3 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP while requester 1 stays valid. Required: `rsp_*` stable throughout; `req_ready` = 0 throughout; requester 1 is granted on the cycle after `rsp_ready` rises.
- Illegal opcode 000, and separately 111, with inA=0x12, inB=0x34. Required: `rsp_err`=1, `rsp_data`=0x00, correct `rsp_id`.
- Reset mid-op: drive `rst_n`=0 for 1 cycle during EXEC. Required: no `rsp_valid` afterwards; `rsp_*`=0; `alu_cmd`=0; next grant searches from requester 0.
- Requester 3 drops `req_valid` while requester 0's transaction is in flight. Required: no response ever carries `rsp_id`=3; `rr_ptr` advances from 1.

Source files
------------

// File: rtl/alu_rr_scheduler_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_rr_scheduler.
// slave is the scheduler's view; master is the surrounding clients/ALU/sink.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*19-1:0] req_cmd;
  logic [18:0]           alu_cmd;
  logic [7:0]            alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [7:0]            rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_cmd, alu_result, rsp_ready,
    output req_ready, alu_cmd, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req_valid, req_cmd, alu_result, rsp_ready,
    input  req_ready, alu_cmd, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter that feeds one command at a time into a shared 8-bit ALU
// and returns the registered result tagged with the requester index.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both 1. req_ready is a pure function of state, rr_ptr and req_valid, so a
// granted requester completes in the same cycle; rsp_* stay stable while
// rsp_valid=1 and rsp_ready=0.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_rr_scheduler_if.slave    bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]      rr_ptr;
  logic [18:0]          cmd_q;
  logic [ID_W-1:0]      id_q;
  logic                 rsp_valid_q;
  logic [7:0]           rsp_data_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic                 rsp_err_q;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [2*NUM_REQ-1:0] valid_rot;
  logic                 found;
  logic [ID_W:0]        offset;
  logic [ID_W:0]        sum;
  logic [ID_W:0]        nsum;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0]   ready_vec;
  logic                 legal;

  // Rotating a doubled copy puts requester rr_ptr at bit 0, so the lowest set
  // bit of the rotated vector is the next requester in round-robin order.
  assign valid_dbl = {bus.req_valid, bus.req_valid};
  assign valid_rot = valid_dbl >> rr_ptr;

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        found  = 1'b1;
        offset = (ID_W+1)'(k);
      end
    end
    sum = {1'b0, rr_ptr} + offset;
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    grant = sum[ID_W-1:0];

    nsum = {1'b0, grant} + (ID_W+1)'(1);
    if (nsum >= (ID_W+1)'(NUM_REQ)) nsum = '0;
    ptr_nxt = nsum[ID_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    ready_vec = '0;
    case (state)
      IDLE: begin
        if (found) begin
          ready_vec[grant] = rst_n;
          state_nxt        = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    case (cmd_q[18:16])
      3'b100, 3'b010, 3'b001, 3'b110, 3'b011: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cmd_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cmd_q  <= bus.req_cmd[19*grant +: 19];
            id_q   <= grant;
            rr_ptr <= ptr_nxt;
          end
        end
        EXEC: begin
          rsp_data_q  <= legal ? bus.alu_result : 8'h00;
          rsp_err_q   <= ~legal;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.alu_cmd   = cmd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state;

endmodule
